// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, default widths and parity helper for the memory request path
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  // Zero-extension leaves the XOR unchanged, so one wide argument serves every word width up to 64.
  function automatic logic parity_err(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_parity_chk.sv
// rtl/mem_parity_chk.sv - even-parity check of a memory word (data plus parity bit in the MSB)
module mem_parity_chk
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic [DATA_W:0] word_i,
  output logic            perr_o
);

  assign perr_o = parity_err(64'(word_i));

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding request sequencer in front of my_mem with parity-checked reads
// Optional saturating parity error counter enabled by MEM_CTRL_ERRCNT_EN.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_perr,
  output logic                mem_write,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W:0]     mem_data_out,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_perr_q, rsp_perr_d;
  logic                perr;

  mem_parity_chk #(.DATA_W(DATA_W)) u_parity_chk (
    .word_i (mem_data_out),
    .perr_o (perr)
  );

  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    rsp_data_d    = rsp_data_q;
    rsp_perr_d    = rsp_perr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_address_d = req_addr;
          mem_data_in_d = req_wdata;
          if (req_write) begin
            state_d     = WR;
            mem_write_d = 1'b1;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
            lat_cnt_d  = '0;
          end
        end
      end
      WR: state_d = IDLE;
      RD: begin
        // Data is valid on the edge closing the last read cycle; capture it and drop mem_read together.
        if (lat_cnt_q == LAT_LAST) begin
          rsp_data_d = mem_data_out[DATA_W-1:0];
          rsp_perr_d = perr;
          state_d    = RESP;
        end else begin
          lat_cnt_d  = lat_cnt_q + 1'b1;
          mem_read_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lat_cnt_q     <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      rsp_data_q    <= '0;
      rsp_perr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      rsp_data_q    <= rsp_data_d;
      rsp_perr_q    <= rsp_perr_d;
    end
  end

  // Gated by rst_n so the request side reads busy for the whole time reset is held.
  assign req_ready   = rst_n && (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_perr    = rsp_perr_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

`ifdef MEM_CTRL_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == RD && state_d == RESP && perr && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench: unit 0 (RD_LAT=1, 16-bit count), unit 1 (RD_LAT=3, 2-bit count)
module tb_mem_req_ctrl;

  localparam int AW = 16;
  localparam int DW = 8;
`ifdef MEM_CTRL_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_perr;
  logic [1:0]           mem_write, mem_read;
  logic [1:0][AW-1:0]   req_addr, mem_address;
  logic [1:0][DW-1:0]   req_wdata, rsp_data, mem_data_in;
  logic [1:0][DW:0]     mem_data_out;
  logic [15:0]          a_err_count;
  logic [1:0]           b_err_count;

  mem_req_ctrl #(.RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_perr(rsp_perr[0]),
    .mem_write(mem_write[0]), .mem_read(mem_read[0]), .mem_address(mem_address[0]),
    .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0]), .err_count(a_err_count)
  );

  mem_req_ctrl #(.RD_LAT(3), .ERRCNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_perr(rsp_perr[1]),
    .mem_write(mem_write[1]), .mem_read(mem_read[1]), .mem_address(mem_address[1]),
    .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1]), .err_count(b_err_count)
  );

  int checks = 0;
  int errors = 0;
  int a_bad = 0;

  // Behavioural memory: stores even-parity words, returns data only in the last cycle of a read pulse.
  logic [8:0] mem_model [int];
  logic [7:0] exp_mem [int];
  int         rd_run [2];
  int         last_len [2];
  int         both_hi = 0;
  logic       force_en [2];
  logic [8:0] force_word [2];

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int exp_errcnt(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return ERRCNT_ON ? ((n > mx) ? mx : n) : 0;
  endfunction

  always @(negedge clk) begin : mem_model_p
    int key;
    for (int u = 0; u < 2; u++) begin
      key = u * 65536 + int'(mem_address[u]);
      if (mem_write[u] && mem_read[u]) both_hi++;
      if (mem_write[u]) mem_model[key] = {^mem_data_in[u], mem_data_in[u]};
      if (mem_read[u]) begin
        rd_run[u]++;
        if (rd_run[u] == lat_of(u))
          mem_data_out[u] = force_en[u] ? force_word[u] : (mem_model.exists(key) ? mem_model[key] : 9'h000);
        else
          mem_data_out[u] = 9'($urandom);
      end else begin
        if (rd_run[u] != 0) last_len[u] = rd_run[u];
        rd_run[u] = 0;
        mem_data_out[u] = 9'($urandom);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int u, input logic w, input logic [15:0] a, input logic [7:0] d);
    int n;
    n = 0;
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a; req_wdata[u] = d;
    while (!req_ready[u] && n < 50) begin tick(); n++; end
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++; $display("FAIL req_ready_timeout unit %0d got %b exp 1", u, req_ready[u]);
    end
    tick();
    req_valid[u] = 1'b0;
  endtask

  task automatic get_rsp(input int u, input int stall, output logic [7:0] d, output logic p);
    int n;
    n = 0;
    while (!rsp_valid[u] && n < 50) begin tick(); n++; end
    checks++;
    if (rsp_valid[u] !== 1'b1) begin
      errors++; $display("FAIL rsp_timeout unit %0d got %b exp 1", u, rsp_valid[u]);
    end
    d = rsp_data[u];
    p = rsp_perr[u];
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if ({rsp_valid[u], rsp_data[u], rsp_perr[u], req_ready[u], mem_read[u], mem_write[u]} !==
          {1'b1, d, p, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rsp_stall unit %0d got v=%b d=%h p=%b rdy=%b rd=%b wr=%b exp v=1 d=%h p=%b rdy=0 rd=0 wr=0",
                 u, rsp_valid[u], rsp_data[u], rsp_perr[u], req_ready[u], mem_read[u], mem_write[u], d, p);
      end
    end
    rsp_ready[u] = 1'b1;
    req_valid[u] = 1'b0;
    tick();
    rsp_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    force_en[0] = 1'b0; force_en[1] = 1'b0; force_word[0] = '0; force_word[1] = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({req_ready[u], rsp_valid[u], mem_write[u], mem_read[u], mem_address[u], mem_data_in[u],
           rsp_data[u], rsp_perr[u]} !== '0) begin
        errors++; $display("FAIL reset_outputs unit %0d got rdy=%b v=%b wr=%b rd=%b a=%h di=%h d=%h p=%b exp all 0",
                           u, req_ready[u], rsp_valid[u], mem_write[u], mem_read[u], mem_address[u],
                           mem_data_in[u], rsp_data[u], rsp_perr[u]);
      end
    end
    checks++;
    if ({a_err_count, b_err_count} !== 18'h0) begin
      errors++; $display("FAIL reset_errcnt got %h/%h exp 0/0", a_err_count, b_err_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready got %b exp 11", req_ready);
    end
    tick();
  endtask

  task automatic test_write();
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h1234; req_wdata[0] = 8'hA5;
    tick();
    req_valid[0] = 1'b0;
    exp_mem[16'h1234] = 8'hA5;
    checks++;
    if ({mem_write[0], mem_read[0], mem_address[0], mem_data_in[0], req_ready[0], rsp_valid[0]} !==
        {1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0, 1'b0}) begin
      errors++; $display("FAIL write_cycle got wr=%b rd=%b a=%h di=%h rdy=%b v=%b exp wr=1 rd=0 a=1234 di=a5 rdy=0 v=0",
                         mem_write[0], mem_read[0], mem_address[0], mem_data_in[0], req_ready[0], rsp_valid[0]);
    end
    tick();
    checks++;
    if ({mem_write[0], req_ready[0], rsp_valid[0], mem_address[0]} !== {1'b0, 1'b1, 1'b0, 16'h1234}) begin
      errors++; $display("FAIL write_done got wr=%b rdy=%b v=%b a=%h exp wr=0 rdy=1 v=0 a=1234",
                         mem_write[0], req_ready[0], rsp_valid[0], mem_address[0]);
    end
  endtask

  task automatic test_read();
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h1234;
    tick();
    req_valid[0] = 1'b0;
    checks++;
    if ({mem_read[0], mem_write[0], mem_address[0], rsp_valid[0], req_ready[0]} !==
        {1'b1, 1'b0, 16'h1234, 1'b0, 1'b0}) begin
      errors++; $display("FAIL read_cycle got rd=%b wr=%b a=%h v=%b rdy=%b exp rd=1 wr=0 a=1234 v=0 rdy=0",
                         mem_read[0], mem_write[0], mem_address[0], rsp_valid[0], req_ready[0]);
    end
    tick();
    checks++;
    if ({rsp_valid[0], mem_read[0], rsp_data[0], rsp_perr[0], a_err_count} !== {1'b1, 1'b0, 8'hA5, 1'b0, 16'h0}) begin
      errors++; $display("FAIL read_resp got v=%b rd=%b d=%h p=%b ec=%h exp v=1 rd=0 d=a5 p=0 ec=0",
                         rsp_valid[0], mem_read[0], rsp_data[0], rsp_perr[0], a_err_count);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    checks++;
    if ({rsp_valid[0], req_ready[0]} !== 2'b01 || last_len[0] != 1) begin
      errors++; $display("FAIL read_done got v=%b rdy=%b pulse=%0d exp v=0 rdy=1 pulse=1",
                         rsp_valid[0], req_ready[0], last_len[0]);
    end
  endtask

  task automatic test_perr();
    logic [7:0] d;
    logic p;
    force_en[0] = 1'b1; force_word[0] = 9'h1A5;
    issue(0, 1'b0, 16'h1234, 8'h00);
    get_rsp(0, 0, d, p);
    force_en[0] = 1'b0;
    a_bad++;
    checks++;
    if ({d, p} !== {8'hA5, 1'b1}) begin
      errors++; $display("FAIL perr_resp got d=%h p=%b exp d=a5 p=1", d, p);
    end
    checks++;
    if (a_err_count !== 16'(exp_errcnt(a_bad, 16))) begin
      errors++; $display("FAIL perr_errcnt got %0d exp %0d", a_err_count, exp_errcnt(a_bad, 16));
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    logic p;
    issue(0, 1'b0, 16'h1234, 8'h00);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'hBEEF; req_wdata[0] = 8'h11;
    get_rsp(0, 5, d, p);
    checks++;
    if ({d, p} !== {8'hA5, 1'b0}) begin
      errors++; $display("FAIL bp_resp got d=%h p=%b exp d=a5 p=0", d, p);
    end
    checks++;
    if ({mem_write[0], mem_address[0], req_ready[0], rsp_valid[0]} !== {1'b0, 16'h1234, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_ignored_req got wr=%b a=%h rdy=%b v=%b exp wr=0 a=1234 rdy=1 v=0",
                         mem_write[0], mem_address[0], req_ready[0], rsp_valid[0]);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    int el;
    logic [7:0] d;
    logic p;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 16'h0100 + 16'(i), 8'h30 + 8'(i));
      exp_mem[16'h0100 + i] = 8'h30 + 8'(i);
    end
    el = int'(($time - t0) / 10);
    checks++;
    if (el != 2 * 3 + 1) begin
      errors++; $display("FAIL b2b_write_rate got %0d cycles exp %0d", el, 7);
    end
    tick();
    t0 = $time;
    issue(0, 1'b0, 16'h0102, 8'h00);
    get_rsp(0, 0, d, p);
    el = int'(($time - t0) / 10);
    checks++;
    if (el != lat_of(0) + 2 || d !== 8'h32 || p !== 1'b0) begin
      errors++; $display("FAIL b2b_read got %0d cycles d=%h p=%b exp %0d cycles d=32 p=0", el, d, p, lat_of(0) + 2);
    end
  endtask

  task automatic test_async_reset();
    issue(0, 1'b0, 16'h1234, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready[0], rsp_valid[0], mem_write[0], mem_read[0], mem_address[0], mem_data_in[0],
         rsp_data[0], rsp_perr[0], a_err_count} !== '0) begin
      errors++; $display("FAIL async_reset got rdy=%b v=%b wr=%b rd=%b a=%h di=%h d=%h p=%b ec=%h exp all 0",
                         req_ready[0], rsp_valid[0], mem_write[0], mem_read[0], mem_address[0],
                         mem_data_in[0], rsp_data[0], rsp_perr[0], a_err_count);
    end
    tick(); tick();
    rst_n = 1'b1;
    a_bad = 0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL async_release_ready got %b exp 1", req_ready[0]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rsp_valid[0], mem_read[0], mem_write[0]} !== 3'b000) begin
        errors++; $display("FAIL async_stale got v=%b rd=%b wr=%b exp 000", rsp_valid[0], mem_read[0], mem_write[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] addrs[$];
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rd;
    logic        p;
    logic [8:0]  w;
    logic        corrupt;
    for (int i = 0; i < 24; i++) begin
      if (addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 16'($urandom); d = 8'($urandom);
        issue(0, 1'b1, a, d);
        exp_mem[int'(a)] = d;
        addrs.push_back(a);
      end else begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        w = {^exp_mem[int'(a)], exp_mem[int'(a)]};
        corrupt = ($urandom_range(0, 3) == 0);
        if (corrupt) w = w ^ (9'h001 << $urandom_range(0, 8));
        force_en[0] = corrupt; force_word[0] = w;
        issue(0, 1'b0, a, 8'h00);
        get_rsp(0, $urandom_range(0, 3), rd, p);
        force_en[0] = 1'b0;
        if (corrupt) a_bad++;
        checks++;
        if ({rd, p} !== {w[7:0], corrupt}) begin
          errors++; $display("FAIL rand_read addr %h got d=%h p=%b exp d=%h p=%b", a, rd, p, w[7:0], corrupt);
        end
        checks++;
        if (a_err_count !== 16'(exp_errcnt(a_bad, 16))) begin
          errors++; $display("FAIL rand_errcnt got %0d exp %0d", a_err_count, exp_errcnt(a_bad, 16));
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] q[$];
    logic [15:0] a;
    logic [15:0] tmp;
    logic [7:0]  d;
    logic [7:0]  rd;
    logic        p;
    logic        dup;
    int          j;
    int          el;
    time         t0;
    q.push_back(16'h0000);
    q.push_back(16'hFFFF);
    while (q.size() < 6) begin
      a = 16'($urandom);
      dup = 1'b0;
      foreach (q[k]) if (q[k] == a) dup = 1'b1;
      if (!dup) q.push_back(a);
    end
    foreach (q[k]) begin
      d = 8'($urandom);
      issue(1, 1'b1, q[k], d);
      exp_mem[65536 + int'(q[k])] = d;
    end
    tick();
    for (int i = 5; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = q[i]; q[i] = q[j]; q[j] = tmp;
    end
    foreach (q[k]) begin
      t0 = $time;
      issue(1, 1'b0, q[k], 8'h00);
      get_rsp(1, 0, rd, p);
      el = int'(($time - t0) / 10);
      checks++;
      if ({rd, p} !== {exp_mem[65536 + int'(q[k])], 1'b0}) begin
        errors++; $display("FAIL sat_readback addr %h got d=%h p=%b exp d=%h p=0", q[k], rd, p, exp_mem[65536 + int'(q[k])]);
      end
      checks++;
      if (last_len[1] != lat_of(1) || el != lat_of(1) + 2) begin
        errors++; $display("FAIL sat_read_timing got pulse=%0d cycles=%0d exp pulse=%0d cycles=%0d",
                           last_len[1], el, lat_of(1), lat_of(1) + 2);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      d = 8'($urandom);
      force_word[1] = {~^d, d}; force_en[1] = 1'b1;
      issue(1, 1'b0, 16'($urandom), 8'h00);
      get_rsp(1, $urandom_range(0, 2), rd, p);
      force_en[1] = 1'b0;
      checks++;
      if ({rd, p} !== {d, 1'b1}) begin
        errors++; $display("FAIL sat_bad_read got d=%h p=%b exp d=%h p=1", rd, p, d);
      end
      checks++;
      if (b_err_count !== 2'(exp_errcnt(k, 2))) begin
        errors++; $display("FAIL sat_errcnt after %0d got %0d exp %0d", k, b_err_count, exp_errcnt(k, 2));
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (both_hi != 0) begin
      errors++; $display("FAIL rd_wr_exclusive got %0d overlaps exp 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_perr();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_saturation();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
